// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder: operands and start request in,
// status and registered result out.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;

  modport master (
    output Start, A, B,
    input  Busy, Done, Sum, Carry
  );

  modport slave (
    input  Start, A, B,
    output Busy, Done, Sum, Carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused LSB-first over WIDTH cycles, with a
// carry flop between bits. Result and status outputs are all registered.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             cflop_q, cflop_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full adder built as two half adders; carry out feeds the carry flop.
  logic ha_p, ha_g, bit_s, bit_c;
  always_comb begin
    ha_p  = a_q[0] ^ b_q[0];
    ha_g  = a_q[0] & b_q[0];
    bit_s = ha_p ^ cflop_q;
    bit_c = ha_g | (cflop_q & ha_p);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    cflop_d = cflop_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          psum_d  = '0;
          cflop_d = 1'b0;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        psum_d  = {bit_s, psum_q[WIDTH-1:1]};
        cflop_d = bit_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          sum_d   = {bit_s, psum_q[WIDTH-1:1]};
          cout_d  = bit_c;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status flags track the state being entered so they line up with it.
    busy_d = (state_d == StAdd);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      cflop_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      cflop_q <= cflop_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;
  assign bus.Sum   = sum_q;
  assign bus.Carry = cout_q;

endmodule
